// File: rtl/dmem_hs.sv
// rtl/dmem_hs.sv - byte-addressed big-endian data memory with valid/ready handshake
// Requests are captured in IDLE, optionally delayed in WAIT, and answered from RESP.
module dmem_hs #(
   parameter int DEPTH_BYTES = 1024,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int AW = (DEPTH_BYTES > 4) ? $clog2(DEPTH_BYTES) : 2;
   localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
   localparam logic [31:0]   LAST_WORD = 32'(DEPTH_BYTES - 4);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [CW-1:0]   r_cnt;
   logic [CW-1:0]   w_cnt_nxt;
   logic            r_write;
   logic [31:0]     r_addr;
   logic [31:0]     r_wdata;
   logic [3:0]      r_be;
   logic            r_resp_valid;
   logic [31:0]     r_rdata;
   logic            r_err;
   logic [7:0]      r_mem [DEPTH_BYTES];

   logic            w_accept;
   logic            w_enter_resp;
   logic            w_idle;
   logic            w_write;
   logic [31:0]     w_addr;
   logic [31:0]     w_wdata;
   logic [3:0]      w_be;
   logic            w_err;
   logic [AW-1:0]   w_base;
   logic [31:0]     w_rdata;

   assign req_ready  = (r_state == S_IDLE) && rst_n;
   assign resp_valid = r_resp_valid;
   assign resp_rdata = r_rdata;
   assign resp_err   = r_err;

   assign w_accept = req_valid && req_ready;
   assign w_idle   = (r_state == S_IDLE);

   // With zero wait states the access happens on the accept edge, before the capture registers load.
   assign w_write = w_idle ? req_write : r_write;
   assign w_addr  = w_idle ? req_addr  : r_addr;
   assign w_wdata = w_idle ? req_wdata : r_wdata;
   assign w_be    = w_idle ? req_be    : r_be;

   assign w_err   = (w_addr[1:0] != 2'b00) || (w_addr > LAST_WORD);
   assign w_base  = w_addr[AW-1:0];
   assign w_rdata = w_err ? 32'h0 :
                    {r_mem[w_base], r_mem[w_base + AW'(1)],
                     r_mem[w_base + AW'(2)], r_mem[w_base + AW'(3)]};

   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_enter_resp = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (WAIT_CYCLES > 0) begin
                  w_state_nxt = S_WAIT;
                  w_cnt_nxt   = CNT_LOAD;
               end else begin
                  w_state_nxt  = S_RESP;
                  w_enter_resp = 1'b1;
               end
            end
         end
         S_WAIT: begin
            if (r_cnt == '0) begin
               w_state_nxt  = S_RESP;
               w_enter_resp = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt - CW'(1);
            end
         end
         S_RESP: begin
            if (r_resp_valid && resp_ready) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_write      <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_be         <= '0;
         r_resp_valid <= 1'b0;
         r_rdata      <= '0;
         r_err        <= 1'b0;
         for (int i = 0; i < DEPTH_BYTES; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_accept) begin
            r_write <= req_write;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_be    <= req_be;
         end
         if (w_enter_resp) begin
            r_resp_valid <= 1'b1;
            r_err        <= w_err;
            r_rdata      <= w_write ? 32'h0 : w_rdata;
            if (w_write && !w_err) begin
               if (w_be[3]) r_mem[w_base]          <= w_wdata[31:24];
               if (w_be[2]) r_mem[w_base + AW'(1)] <= w_wdata[23:16];
               if (w_be[1]) r_mem[w_base + AW'(2)] <= w_wdata[15:8];
               if (w_be[0]) r_mem[w_base + AW'(3)] <= w_wdata[7:0];
            end
         end else if (r_state == S_RESP && resp_ready) begin
            r_resp_valid <= 1'b0;
            r_rdata      <= '0;
            r_err        <= 1'b0;
         end
      end
   end

endmodule
